// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 2;
  localparam int unsigned DEF_DATA_WIDTH = 1;

  // Wrap pointer: low DEF_ADDR_WIDTH bits address the RAM, MSB is the wrap bit.
  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/ram_fifo_ctrl_fifo_ptr.sv
// Enabled modulo-2**WIDTH counter with synchronous active-high reset.
module fifo_ptr #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] ptr_d;
  logic [WIDTH-1:0] ptr_q;

  // Next pointer: advance by one on enable, wrapping naturally at 2**WIDTH.
  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = ptr_q + WIDTH'(1);
  end

  // Pointer register with synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external RAM with combinational read data.
// Stored words live only in the RAM; this block holds the two wrap pointers.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] WADDR,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WE,
  output logic [ADDR_WIDTH-1:0] RADDR,
  input  logic [DATA_WIDTH-1:0] RDATA,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                push;
  logic                pop;

  // Handshakes and status flags, all derived from the registered pointers.
  always_comb begin
    full      = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    empty     = (wr_ptr == rd_ptr);
    count     = wr_ptr - rd_ptr;
    in_ready  = ~full;
    out_valid = ~empty;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // RAM port mapping; the write strobe is suppressed while reset is held.
  always_comb begin
    WADDR    = wr_ptr[ADDR_WIDTH-1:0];
    WDATA    = in_data;
    WE       = push & ~RESET;
    RADDR    = rd_ptr[ADDR_WIDTH-1:0];
    out_data = RDATA;
  end

  fifo_ptr #(.WIDTH(ADDR_WIDTH + 1)) u_wr_ptr (
    .clk (CLK),
    .rst (RESET),
    .en  (push),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.WIDTH(ADDR_WIDTH + 1)) u_rd_ptr (
    .clk (CLK),
    .rst (RESET),
    .en  (pop),
    .ptr (rd_ptr)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized self-checking bench for ram_fifo_ctrl (depth 4, width 1) with a RAM4x1 model.
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [0:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] WADDR;
  logic [0:0] WDATA;
  logic       WE;
  logic [1:0] RADDR;
  logic [0:0] RDATA;
  logic [2:0] count;
  logic       full;
  logic       empty;

  ram_fifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(1)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .WADDR     (WADDR),
    .WDATA     (WDATA),
    .WE        (WE),
    .RADDR     (RADDR),
    .RDATA     (RDATA),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 CLK = ~CLK;

  // RAM4x1 model: synchronous write, combinational read, never reset.
  logic [0:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 1'b0;
  always @(posedge CLK) if (WE) mem[WADDR] <= WDATA;
  assign RDATA = mem[RADDR];

  // Reference model: a queue of stored words plus total push/pop counts.
  bit [0:0] model_q[$];
  int       wr_total;
  int       rd_total;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit rst, input bit iv, input bit d, input bit ordy);
    int  sz;
    bit  exp_push;
    bit  exp_pop;
    @(negedge CLK);
    RESET     = rst;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    sz       = model_q.size();
    exp_push = iv && (sz < DEPTH);
    exp_pop  = ordy && (sz > 0);
    check("count",     32'(count),     32'(sz));
    check("full",      32'(full),      32'(sz == DEPTH));
    check("empty",     32'(empty),     32'(sz == 0));
    check("in_ready",  32'(in_ready),  32'(sz != DEPTH));
    check("out_valid", 32'(out_valid), 32'(sz != 0));
    check("WE",        32'(WE),        32'(exp_push && !rst));
    check("WADDR",     32'(WADDR),     32'(wr_total % DEPTH));
    check("RADDR",     32'(RADDR),     32'(rd_total % DEPTH));
    check("WDATA",     32'(WDATA),     32'(d));
    if (sz > 0) check("out_data", 32'(out_data), 32'(model_q[0]));
    @(posedge CLK);
    if (rst) begin
      model_q.delete();
      wr_total = 0;
      rd_total = 0;
    end else begin
      if (exp_pop) begin
        void'(model_q.pop_front());
        rd_total++;
      end
      if (exp_push) begin
        model_q.push_back(d);
        wr_total++;
      end
    end
  endtask

  initial begin
    bit [3:0] pat;
    RESET = 1'b1; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b0;
    wr_total = 0; rd_total = 0;
    pat = 4'b1101;  // pushed LSB first: 1,0,1,1

    // Reset, then idle.
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // Fill with 1,0,1,1, then a fifth in_valid against a full FIFO.
    for (int i = 0; i < 4; i++) step(0, 1, pat[i], 0);
    step(0, 1, 1, 0);
    check("full_after_fill", 32'(full), 32'd1);

    // Drain in order.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Build count=2, then 10 cycles of simultaneous push and pop across the wrap.
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1'($urandom_range(0, 1)), 1);
    check("count_steady", 32'(count), 32'd2);

    // Push a 1 to reach count=3 (lands at address 0), then reset with traffic pending.
    step(0, 1, 1, 0);
    step(1, 1, 1, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("readback_after_reset", 32'(out_data), 32'd0);

    // Full with in_valid and out_ready together: one pop, no push.
    for (int i = 0; i < 3; i++) step(0, 1, 1'($urandom_range(0, 1)), 0);
    step(0, 1, 1, 1);
    step(0, 0, 0, 0);
    check("count_after_full_pop", 32'(count), 32'd3);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
